// File: rtl/th_mdarray_rr_fifo.sv
// th_mdarray_rr_fifo: NCH per-channel FIFOs of packed ROWS x COLS words
// drained by one output, either round-robin (MODE 0) or wand merge (MODE 1).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  per-channel push handshake (NCH bits each)
//   in_data         NCH words, channel c at [c*W +: W]
//   out_valid/ready output handshake
//   out_data        selected word (MODE 0) or AND of all heads (MODE 1)
//   out_ch          source channel of out_data (0 in MODE 1)
//   level           per-channel occupancy, channel c at [c*LW +: LW]
module th_mdarray_rr_fifo #(
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int MODE  = 0,
    localparam int W  = ROWS * COLS,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic [NCH*LW-1:0] level
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    typedef logic [ROWS-1:0][COLS-1:0] word_t;

    word_t          mem  [NCH][DEPTH];
    word_t          head [NCH];
    logic [PW-1:0]  wptr [NCH];
    logic [PW-1:0]  rptr [NCH];
    logic [LW-1:0]  cnt  [NCH];

    logic [NCH-1:0] nempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [CW-1:0]  gptr;
    logic [CW-1:0]  hold_ch;
    logic [CW-1:0]  rr_sel;
    logic [CW-1:0]  sel;
    logic [CW:0]    idx;
    logic           found;
    logic [0:0]     state;
    logic           any_v;
    logic           all_v;
    logic           pop_any;
    word_t          merged;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            nempty[c]            = cnt[c] != '0;
            head[c]              = mem[c][rptr[c]];
            // Full check uses only the registered count, so a
            // same-cycle pop never frees a slot for a push.
            in_ready[c]          = cnt[c] != LW'(DEPTH);
            push[c]              = in_valid[c] & in_ready[c];
            level[c*LW +: LW]    = cnt[c];
        end
    end

    // First nonempty channel at or after gptr, with wrap.
    always_comb begin
        rr_sel = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = {1'b0, gptr} + (CW+1)'(i);
            if (idx >= (CW+1)'(NCH))
                idx = idx - (CW+1)'(NCH);
            if (!found && nempty[idx[CW-1:0]]) begin
                found  = 1'b1;
                rr_sel = idx[CW-1:0];
            end
        end
    end

    // A stalled word keeps its channel until it is taken.
    assign sel = (state == HOLD) ? hold_ch : rr_sel;

    always_comb begin
        merged = '1;
        for (int c = 0; c < NCH; c++)
            merged = merged & head[c];
    end

    assign any_v = |nempty;
    assign all_v = &nempty;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_ch    = '0;
        if (MODE == 0) begin
            out_valid = any_v;
            if (any_v) begin
                out_data = head[sel];
                out_ch   = sel;
            end
        end else begin
            out_valid = all_v;
            if (all_v)
                out_data = merged;
        end
    end

    assign pop_any = out_valid & out_ready;

    always_comb begin
        pop = '0;
        if (pop_any) begin
            if (MODE == 0)
                pop[sel] = 1'b1;
            else
                pop = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c]  <= '0;
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c])
                    wptr[c] <= wptr[c] + PW'(1);
                if (pop[c])
                    rptr[c] <= rptr[c] + PW'(1);
                cnt[c] <= cnt[c] + LW'(push[c]) - LW'(pop[c]);
            end
        end
    end

    // Word storage is never reset; only written slots are presented.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++)
            if (push[c])
                mem[c][wptr[c]] <= in_data[c*W +: W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gptr    <= '0;
            hold_ch <= '0;
        end else if (MODE == 0) begin
            if (pop_any)
                gptr <= (sel == CW'(NCH - 1)) ? '0 : sel + CW'(1);
            case (state)
                IDLE: begin
                    if (out_valid && !out_ready) begin
                        state   <= HOLD;
                        hold_ch <= sel;
                    end
                end
                HOLD: begin
                    if (pop_any)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_th_mdarray_rr_fifo.sv
// tb_th_mdarray_rr_fifo: bench for th_mdarray_rr_fifo, one instance per MODE,
// queue-based reference model compared every cycle plus directed literals.
module tb_th_mdarray_rr_fifo;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int W     = 9;
    localparam int CW    = 2;
    localparam int LW    = 3;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    iv0, iv1, ir0, ir1;
    logic [NCH*W-1:0]  id0, id1;
    logic              ov0, ov1, ordy0, ordy1;
    logic [W-1:0]      od0, od1;
    logic [CW-1:0]     oc0, oc1;
    logic [NCH*LW-1:0] lv0, lv1;

    int tests;
    int fails;

    logic [W-1:0] q0 [NCH][$];
    logic [W-1:0] q1 [NCH][$];
    int           gptr_m;
    int           hch_m;
    bit           hold_m;

    th_mdarray_rr_fifo #(.NCH(NCH), .DEPTH(DEPTH), .ROWS(3), .COLS(3), .MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
        .out_ch(oc0), .level(lv0)
    );

    th_mdarray_rr_fifo #(.NCH(NCH), .DEPTH(DEPTH), .ROWS(3), .COLS(3), .MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
        .out_ch(oc1), .level(lv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m0_sel();
        if (hold_m) return hch_m;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (gptr_m + i) % NCH;
            if (q0[c].size() > 0) return c;
        end
        return -1;
    endfunction

    function automatic bit m1_all();
        for (int c = 0; c < NCH; c++)
            if (q1[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] m1_and();
        logic [W-1:0] v;
        v = '1;
        for (int c = 0; c < NCH; c++) v = v & q1[c][0];
        return v;
    endfunction

    function automatic logic [NCH*LW-1:0] m_lvl(input bit m);
        logic [NCH*LW-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++)
            v[c*LW +: LW] = m ? LW'(q1[c].size()) : LW'(q0[c].size());
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_rdy(input bit m);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++)
            v[c] = m ? (q1[c].size() != DEPTH) : (q0[c].size() != DEPTH);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            q0[c].delete();
            q1[c].delete();
        end
        gptr_m = 0;
        hch_m  = 0;
        hold_m = 1'b0;
    endtask

    task automatic model_update();
        bit acc0 [NCH];
        bit acc1 [NCH];
        int s;
        bit all;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            acc0[c] = iv0[c] && (q0[c].size() < DEPTH);
            acc1[c] = iv1[c] && (q1[c].size() < DEPTH);
        end
        s = m0_sel();
        if (s >= 0 && ordy0) begin
            void'(q0[s].pop_front());
            gptr_m = (s + 1) % NCH;
            hold_m = 1'b0;
        end else if (s >= 0) begin
            hold_m = 1'b1;
            hch_m  = s;
        end
        all = m1_all();
        if (all && ordy1)
            for (int c = 0; c < NCH; c++) void'(q1[c].pop_front());
        for (int c = 0; c < NCH; c++) begin
            if (acc0[c]) q0[c].push_back(id0[c*W +: W]);
            if (acc1[c]) q1[c].push_back(id1[c*W +: W]);
        end
    endtask

    // Every cycle: both instances against the model.
    initial begin
        forever begin
            int s;
            bit all;
            @(negedge clk);
            s = m0_sel();
            chk("m0 out_valid", 32'(ov0), 32'(s >= 0));
            chk("m0 out_ch", 32'(oc0), (s >= 0) ? s : 0);
            chk("m0 out_data", 32'(od0), (s >= 0) ? 32'(q0[s][0]) : 0);
            chk("m0 in_ready", 32'(ir0), 32'(m_rdy(1'b0)));
            chk("m0 level", 32'(lv0), 32'(m_lvl(1'b0)));
            all = m1_all();
            chk("m1 out_valid", 32'(ov1), 32'(all));
            chk("m1 out_ch", 32'(oc1), 0);
            chk("m1 out_data", 32'(od1), all ? 32'(m1_and()) : 0);
            chk("m1 in_ready", 32'(ir1), 32'(m_rdy(1'b1)));
            chk("m1 level", 32'(lv1), 32'(m_lvl(1'b1)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push0(input logic [NCH-1:0] m, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic [W-1:0] d2);
        iv0 = m;
        id0 = {d2, d1, d0};
        step();
        iv0 = '0;
    endtask

    logic [CW-1:0] exp_ch [6];
    logic [W-1:0]  exp_d  [6];

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        iv0 = '0; iv1 = '0; id0 = '0; id1 = '0;
        ordy0 = 1'b0; ordy1 = 1'b0;
        model_reset();

        // Reset state, then single push on ch1
        do_reset();
        chk("rst in_ready", 32'(ir0), 32'h7);
        chk("rst out_valid", 32'(ov0), 0);
        chk("rst level", 32'(lv0), 0);
        chk("rst out_data", 32'(od0), 0);
        iv0 = 3'b010;
        id0 = {9'h000, 9'h1A5, 9'h000};
        chk("push cycle out_valid", 32'(ov0), 0);
        step();
        iv0 = '0;
        chk("single out_valid", 32'(ov0), 1);
        chk("single out_ch", 32'(oc0), 1);
        chk("single out_data", 32'(od0), 32'h1A5);
        chk("single level1", 32'(lv0[LW +: LW]), 1);

        // Round-robin fairness
        do_reset();
        push0(3'b111, 9'h0A0, 9'h0A1, 9'h0A2);
        push0(3'b111, 9'h0B0, 9'h0B1, 9'h0B2);
        exp_ch = '{0, 1, 2, 0, 1, 2};
        exp_d  = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0B0, 9'h0B1, 9'h0B2};
        ordy0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("rr out_ch", 32'(oc0), 32'(exp_ch[k]));
            chk("rr out_data", 32'(od0), 32'(exp_d[k]));
            step();
        end
        chk("rr drained", 32'(ov0), 0);
        ordy0 = 1'b0;

        // Hold keeps ch2 even though ch0 is ahead of it in search order
        push0(3'b100, 9'h000, 9'h000, 9'h0E7);
        step();
        push0(3'b001, 9'h011, 9'h000, 9'h000);
        chk("hold over ch0 out_ch", 32'(oc0), 2);
        chk("hold over ch0 out_data", 32'(od0), 32'h0E7);
        ordy0 = 1'b1;
        step();
        chk("after hold out_ch", 32'(oc0), 0);
        chk("after hold out_data", 32'(od0), 32'h011);
        step();
        ordy0 = 1'b0;

        // HOLD stability with grant_ptr = 2
        push0(3'b010, 9'h000, 9'h1AA, 9'h000);
        ordy0 = 1'b1;
        step();
        ordy0 = 1'b0;
        push0(3'b100, 9'h000, 9'h000, 9'h055);
        push0(3'b001, 9'h011, 9'h000, 9'h000);
        for (int k = 0; k < 5; k++) begin
            chk("hold out_ch", 32'(oc0), 2);
            chk("hold out_data", 32'(od0), 32'h055);
            step();
        end
        ordy0 = 1'b1;
        step();
        ordy0 = 1'b0;
        chk("hold release out_ch", 32'(oc0), 0);
        chk("hold release out_data", 32'(od0), 32'h011);
        ordy0 = 1'b1;
        step();
        ordy0 = 1'b0;
        chk("hold drained", 32'(ov0), 0);

        // Full boundary
        for (int k = 0; k < DEPTH; k++)
            push0(3'b001, 9'(9'h100 + k), 9'h000, 9'h000);
        chk("full in_ready", 32'(ir0), 32'h6);
        chk("full level0", 32'(lv0[0 +: LW]), 4);
        iv0 = 3'b001;
        id0 = {9'h000, 9'h000, 9'h104};
        ordy0 = 1'b1;
        step();
        iv0 = '0;
        ordy0 = 1'b0;
        chk("full+pop level0", 32'(lv0[0 +: LW]), 3);
        chk("full+pop in_ready", 32'(ir0), 32'h7);
        ordy0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("full drain data", 32'(od0), 32'h101 + k);
            step();
        end
        chk("fifth absent", 32'(ov0), 0);
        ordy0 = 1'b0;

        // Wand merge
        iv1 = 3'b111;
        id1 = {9'h13C, 9'h0F3, 9'h1FF};
        step();
        iv1 = 3'b101;
        id1 = {9'h155, 9'h000, 9'h0AA};
        step();
        iv1 = '0;
        chk("wand out_valid", 32'(ov1), 1);
        chk("wand out_data", 32'(od1), 32'h030);
        chk("wand out_ch", 32'(oc1), 0);
        chk("wand level", 32'(lv1), {23'd0, 3'd2, 3'd1, 3'd2});
        ordy1 = 1'b1;
        step();
        ordy1 = 1'b0;
        chk("wand pop level", 32'(lv1), {23'd0, 3'd1, 3'd0, 3'd1});
        chk("wand ch1 empty valid", 32'(ov1), 0);
        chk("wand ch1 empty data", 32'(od1), 0);

        // Async reset in HOLD, grant_ptr nonzero beforehand
        push0(3'b100, 9'h000, 9'h000, 9'h0E7);
        step();
        push0(3'b010, 9'h000, 9'h022, 9'h000);
        chk("pre-reset hold ch", 32'(oc0), 2);
        #4;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async out_valid", 32'(ov0), 0);
        chk("async level", 32'(lv0), 0);
        chk("async in_ready", 32'(ir0), 32'h7);
        chk("async m1 level", 32'(lv1), 0);
        #1;
        rst = 1'b0;
        push0(3'b101, 9'h0C3, 9'h000, 9'h0E7);
        chk("post-reset out_valid", 32'(ov0), 1);
        chk("post-reset out_ch", 32'(oc0), 0);
        chk("post-reset out_data", 32'(od0), 32'h0C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/th_mdarray_rr_fifo.md
Name: th_mdarray_rr_fifo

Overview:
- Parametrised multi-channel buffer for packed multidimensional words (ROWS x COLS bits, row-major).
- Each of NCH input channels feeds its own DEPTH-entry FIFO.
- A single output drains the FIFOs in one of two modes, fixed at elaboration:
  - round-robin arbitration, or
  - wired-AND merge, which matches wand net resolution.
- Successor to the fixed-shape packed-array port blocks. It adds channel count, depth, storage, arbitration and backpressure.

Parameters:
- NCH, 3: number of input channels; 2..8.
- DEPTH, 4: entries per channel FIFO; power of two, 2..16.
- ROWS, 3: packed outer dimension of a word.
- COLS, 3: packed inner dimension of a word. Word width W = ROWS*COLS.
- MODE, 0: 0 = round-robin; 1 = wand merge.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  NCH  per-channel push request.
- in_ready  output  NCH  per-channel space available.
- in_data  input  NCH x W  per-channel word; channel c at bits [c*W +: W].
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  W  output word.
- out_ch  output  clog2(NCH)  source channel of out_data; 0 in MODE 1.
- level  output  NCH x clog2(DEPTH+1)  per-channel occupancy.

Behaviour:
- Reset is asynchronous on rst high and holds while rst is high. It clears:
  - all counts, read pointers and write pointers;
  - the grant pointer, to 0;
  - the FSM, to IDLE.
- Reset values and register data:
  - Outputs during and after reset: in_ready all ones, out_valid 0, out_ch 0, level 0, out_data 0.
  - Storage contents are not reset. Only entries that have been written are ever presented.
- Push rules:
  - in_ready[c] = (level[c] != DEPTH) and depends only on registered count.
  - When full, no push is accepted even if the same channel pops in that cycle.
  - A push occurs when in_valid[c] and in_ready[c] are both high.
- Pop and occupancy:
  - A pop occurs on out_valid and out_ready.
  - A simultaneous push and pop on one channel leaves its count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: a word pushed at edge N is visible at the output at the earliest in the cycle after edge N. There is no combinational in-to-out path.
- MODE 0, out_valid: out_valid is high if any channel is nonempty.
- MODE 0, grant selection: the selected channel is the first nonempty channel searching upward from grant_ptr, with wrap.
- MODE 0, FSM with states IDLE and HOLD:
  - IDLE -> HOLD when out_valid and not out_ready. The current selection is latched.
  - In HOLD, out_ch and out_data stay on the latched channel's head, even if other channels receive pushes.
  - HOLD -> IDLE on pop.
  - IDLE stays IDLE on pop or when no word is valid.
- MODE 0, grant pointer update: on every pop, grant_ptr = (popped channel + 1) mod NCH. Without a pop, grant_ptr is unchanged.
- MODE 1:
  - out_valid is high only when every channel is nonempty.
  - out_data is the bitwise AND of all NCH head words.
  - A pop removes one entry from every channel in the same cycle.
  - The FSM stays in IDLE.
- When out_valid is 0, out_data is 0 and out_ch is 0 (deterministic, no X).
- Reset mid-operation: all buffered words are discarded. HOLD is abandoned, and the first post-reset pop comes from channel 0 if it is nonempty.

Test Plan:
- Reset, then single push:
  - Stimulus: assert rst, release; push 9'h1A5 on ch1 only.
  - Required: out_valid=0 in the push cycle; next cycle out_valid=1, out_ch=1, out_data=9'h1A5, level[1]=1.
- MODE 0 fairness:
  - Stimulus: fill ch0..ch2 with words 0xA0+c, 0xB0+c; hold out_ready=1.
  - Required pop order (ch, data): (0,A0) (1,A1) (2,A2) (0,B0) (1,B1) (2,B2); out_valid drops after the sixth pop.
- HOLD stability:
  - Stimulus: ch2 holds 9'h055 with grant_ptr=2 and out_ready=0; then push ch0.
  - Required: out_ch=2 and out_data=9'h055 stay stable for 5 cycles; raising out_ready pops ch2, then ch0 is presented.
- Full boundary:
  - Stimulus: push DEPTH=4 words on ch0 with out_ready=0.
  - Required: in_ready[0]=0 and level[0]=4. A fifth push with a simultaneous pop is rejected: level becomes 3 and the fifth word is absent.
- MODE 1 merge:
  - Stimulus: heads 9'h1FF, 9'h0F3, 9'h13C.
  - Required: out_data=9'h030 and out_ch=0; one pop decrements all levels. With ch1 empty, out_valid=0.
- Async reset mid-HOLD:
  - Stimulus: pulse rst between clock edges while in HOLD.
  - Required: out_valid=0 and level=0 immediately, without waiting for a clock edge; a later push on ch0 yields out_ch=0.
